// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address (SLV_ADDR). By default it only accepts master writes.
// Define I2C_SLAVE_READ_EN to also serve master reads from tx_data.
module i2c_slave #(
  parameter logic [6:0] SLV_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  input  logic [7:0] tx_data,
  output logic       tx_req
);

`ifdef I2C_SLAVE_READ_EN
  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRx, StRxAck, StIgnore, StTx, StTxAck
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRx, StRxAck, StIgnore
  } state_e;
`endif

  state_e      state_q, state_d;
  logic        scl_meta_q, scl_sync_q, scl_hist_q;
  logic        sda_meta_q, sda_sync_q, sda_hist_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, shift_in;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        busy_q, busy_d;
  logic        scl_rise, scl_fall, start_det, stop_det, addr_ok;

  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
  assign shift_in  = {shift_q[6:0], sda_sync_q};

  // Open-drain: only ever pull low or float.
  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

`ifdef I2C_SLAVE_READ_EN
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       load_tx;
  assign tx_req  = tx_req_q;
  assign addr_ok = (shift_in[7:1] == SLV_ADDR);
`else
  logic unused_tx_data;
  assign unused_tx_data = ^tx_data;
  assign tx_req         = 1'b0;
  assign addr_ok        = (shift_in[7:1] == SLV_ADDR) && !shift_in[0];
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
`ifdef I2C_SLAVE_READ_EN
    tx_shift_d = tx_shift_q;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    load_tx    = 1'b0;
`endif
    // Bus conditions override any SCL edge seen in the same cycle.
    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (addr_ok) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
`ifdef I2C_SLAVE_READ_EN
                rw_d    = shift_in[0];
`endif
              end else begin
                state_d = StIgnore;
                busy_d  = 1'b0;
              end
            end
          end
        end
        // First falling edge starts the ACK pulse, the second one ends it.
        StAddrAck, StRxAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = StRx;
`ifdef I2C_SLAVE_READ_EN
              if (state_q == StAddrAck && rw_q) load_tx = 1'b1;
`endif
            end
          end
        end
        StRx: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = '0;
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              state_d    = StRxAck;
            end
          end
        end
`ifdef I2C_SLAVE_READ_EN
        StTx: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = StTxAck;
            end else begin
              sda_oe_d   = ~tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
        // bit_cnt doubles as the "master ACKed" flag between rise and fall.
        StTxAck: begin
          if (scl_rise) begin
            if (sda_sync_q) begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            load_tx = 1'b1;
          end
        end
`endif
        default: sda_oe_d = 1'b0;
      endcase
    end
`ifdef I2C_SLAVE_READ_EN
    // Capture a byte and put its MSB on the bus on this falling edge.
    if (load_tx) begin
      tx_req_d   = 1'b1;
      sda_oe_d   = ~tx_data[7];
      tx_shift_d = {tx_data[6:0], 1'b0};
      bit_cnt_d  = '0;
      state_d    = StTx;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_meta_q <= SCL;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= SDA;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

`ifdef I2C_SLAVE_READ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift_q <= '0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a table of write transactions plus hand-written
// repeated-start, reset-mid-ACK and read (or read-refusal) sequences.
`timescale 1ns/1ps
module tb_i2c_slave;
  localparam int H = 10;  // clk cycles per SCL phase

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_oe;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, busy, tx_req;
  wire        sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(.SLV_ADDR(7'h3C)) dut (
    .clk     (clk),
    .reset   (reset),
    .SCL     (scl),
    .SDA     (sda),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .tx_data (tx_data),
    .tx_req  (tx_req)
  );

  // Free-running monitors; tests take snapshots and compare deltas.
  int         n_valid = 0, n_txreq = 0, busy_cnt = 0, low_cnt = 0;
  logic [7:0] rx_log[$];
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid <= n_valid + 1;
      rx_log.push_back(rx_data);
    end
    if (tx_req) n_txreq <= n_txreq + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (!m_oe && sda == 1'b0) low_cnt <= low_cnt + 1;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_oe = 1'b0; clks(H);
    scl  = 1'b1; clks(H);
    m_oe = 1'b1; clks(H);
    scl  = 1'b0; clks(H);
  endtask

  task automatic bus_stop();
    clks(2);
    m_oe = 1'b1; clks(H);
    scl  = 1'b1; clks(H);
    m_oe = 1'b0; clks(H);
  endtask

  task automatic bit_xfer(input logic b, output logic seen);
    clks(2);
    m_oe = ~b; clks(H - 2);
    scl  = 1'b1; clks(H / 2);
    seen = sda; clks(H / 2);
    scl  = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(nack, s);
  endtask

  typedef struct {
    logic [7:0] addr;
    int         nbytes;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } wvec_t;

  wvec_t vecs[4];

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] rd;
    logic [7:0] db;
    int         v0, b0, l0, t0;

    vecs[0] = '{addr: 8'h78, nbytes: 2, d0: 8'hA5, d1: 8'h5A, exp_ack: 1'b1};
    vecs[1] = '{addr: 8'h7A, nbytes: 1, d0: 8'h11, d1: 8'h00, exp_ack: 1'b0};
    vecs[2] = '{addr: 8'h78, nbytes: 2, d0: 8'h00, d1: 8'hFF, exp_ack: 1'b1};
    vecs[3] = '{addr: 8'h3C, nbytes: 1, d0: 8'h55, d1: 8'h00, exp_ack: 1'b0};

    reset = 1'b1; scl = 1'b1; m_oe = 1'b0; tx_data = 8'hC3;
    clks(3);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_tx_req", tx_req, 1'b0);
    check("reset_sda", sda, 1'b1);
    reset = 1'b0;
    clks(5);

    for (int k = 0; k < 4; k++) begin
      v0 = n_valid; b0 = busy_cnt; l0 = low_cnt;
      bus_start();
      write_byte(vecs[k].addr, ack);
      check($sformatf("v%0d_addr_ack", k), ack, vecs[k].exp_ack);
      for (int j = 0; j < vecs[k].nbytes; j++) begin
        db = (j == 0) ? vecs[k].d0 : vecs[k].d1;
        write_byte(db, ack);
        check($sformatf("v%0d_data%0d_ack", k, j), ack, vecs[k].exp_ack);
      end
      bus_stop();
      clks(4);
      check($sformatf("v%0d_busy_after_stop", k), busy, 1'b0);
      check($sformatf("v%0d_rx_valid_count", k), n_valid - v0,
            vecs[k].exp_ack ? vecs[k].nbytes : 0);
      check($sformatf("v%0d_busy_seen", k), busy_cnt != b0, vecs[k].exp_ack);
      if (vecs[k].exp_ack) begin
        for (int j = 0; j < vecs[k].nbytes; j++) begin
          db = (j == 0) ? vecs[k].d0 : vecs[k].d1;
          if (n_valid > v0 + j) check($sformatf("v%0d_rx_data%0d", k, j), rx_log[v0 + j], db);
        end
      end else begin
        check($sformatf("v%0d_sda_never_low", k), low_cnt - l0, 0);
      end
    end

    // Repeated start after half a byte: partial byte must vanish.
    v0 = n_valid;
    bus_start();
    write_byte(8'h78, ack);
    check("rs_addr1_ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, s);
    bus_start();
    check("rs_busy_cleared", busy, 1'b0);
    write_byte(8'h78, ack);
    check("rs_addr2_ack", ack, 1'b1);
    write_byte(8'h3C, ack);
    bus_stop();
    clks(4);
    check("rs_rx_valid_count", n_valid - v0, 1);
    if (n_valid > v0) check("rs_rx_data", rx_log[v0], 8'h3C);

    // Reset while the address ACK is being driven.
    bus_start();
    db = 8'h78;
    for (int i = 7; i >= 0; i--) bit_xfer(db[i], s);
    m_oe = 1'b0;
    clks(H / 2);
    check("mid_ack_driven", sda, 1'b0);
    check("mid_ack_busy", busy, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_ack_reset_sda", sda, 1'b1);
    check("mid_ack_reset_busy", busy, 1'b0);
    check("mid_ack_reset_rx_data", rx_data, 8'h00);
    check("mid_ack_reset_rx_valid", rx_valid, 1'b0);
    clks(2);
    reset = 1'b0;
    clks(H / 2);
    scl = 1'b1; clks(H);
    scl = 1'b0;
    v0 = n_valid; l0 = low_cnt; b0 = busy_cnt;
    write_byte(8'h12, ack);
    check("post_reset_no_ack", ack, 1'b0);
    bus_stop();
    clks(4);
    check("post_reset_no_valid", n_valid - v0, 0);
    check("post_reset_sda_never_low", low_cnt - l0, 0);
    check("post_reset_busy_never", busy_cnt - b0, 0);

`ifdef I2C_SLAVE_READ_EN
    t0 = n_txreq; b0 = busy_cnt;
    tx_data = 8'hC3;
    bus_start();
    write_byte(8'h79, ack);
    check("rd_addr_ack", ack, 1'b1);
    read_byte(1'b1, rd);
    check("rd_byte", rd, 8'hC3);
    bus_stop();
    clks(4);
    check("rd_tx_req_count", n_txreq - t0, 1);
    check("rd_busy_after_stop", busy, 1'b0);
    check("rd_busy_seen", busy_cnt != b0, 1'b1);
    // Back in idle: a plain write must still work.
    v0 = n_valid;
    bus_start();
    write_byte(8'h78, ack);
    write_byte(8'h21, ack);
    bus_stop();
    clks(4);
    check("rd_then_wr_valid", n_valid - v0, 1);
    if (n_valid > v0) check("rd_then_wr_data", rx_log[v0], 8'h21);
`else
    t0 = n_txreq; l0 = low_cnt;
    bus_start();
    write_byte(8'h79, ack);
    check("rd_off_nack", ack, 1'b0);
    bus_stop();
    clks(4);
    check("rd_off_tx_req", n_txreq - t0, 0);
    check("rd_off_sda_never_low", low_cnt - l0, 0);
    check("rd_off_busy", busy, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
